// File: rtl/rotary_pkg.sv
// rotary_pkg: shared direction/mode encodings and the acceleration state type
// for the rotary position counter.
package rotary_pkg;
  localparam logic DIR_CW    = 1'b1;
  localparam logic DIR_CCW   = 1'b0;
  localparam logic MODE_SAT  = 1'b0;
  localparam logic MODE_WRAP = 1'b1;
  typedef enum logic {ACC_SLOW, ACC_FAST} acc_state_e;
endpackage

// File: rtl/rotary_position_counter_accel.sv
// rotary_accel_ctrl: gap timer plus SLOW/FAST state machine; o_fast marks a pulse
// that should use the multiplied step. Used only when ROTARY_POS_ACCEL_EN is defined.
module rotary_accel_ctrl
  import rotary_pkg::*;
#(
  parameter int FAST_GAP = 50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_cnt,
  input  logic i_cnt_cw,
  input  logic i_load,
  output logic o_fast
);
  localparam int TW = $clog2(FAST_GAP + 1);
  localparam logic [TW-1:0] GAP = TW'(FAST_GAP);
  acc_state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic dir_q, dir_d, seen_q, seen_d, pulse, fast_go;
  always_comb begin
    pulse   = i_cnt && !i_load;
    // seen_q keeps the very first pulse after reset slow: there is no previous direction yet
    fast_go = pulse && timer_q < GAP && i_cnt_cw == dir_q && (state_q == ACC_FAST || seen_q);
    timer_d = pulse ? '0 : (timer_q == GAP ? timer_q : timer_q + 1'b1);
    dir_d   = pulse ? i_cnt_cw : dir_q;
    seen_d  = seen_q || pulse;
    state_d = fast_go ? ACC_FAST : (i_load || pulse || timer_q == GAP) ? ACC_SLOW : state_q;
    o_fast  = fast_go;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ACC_SLOW;
      timer_q <= '0;
      dir_q   <= DIR_CW;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dir_q   <= dir_d;
      seen_q  <= seen_d;
    end
  end
endmodule

// File: rtl/rotary_position_counter.sv
// rotary_position_counter: accumulates encoder step pulses into a bounded position with
// saturate or wrap overflow; optional step acceleration under ROTARY_POS_ACCEL_EN.
module rotary_position_counter
  import rotary_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int POS_MIN    = 0,
  parameter int POS_MAX    = 255,
  parameter int POS_RESET  = 0,
  parameter int STEP       = 1,
  parameter int FAST_GAP   = 50000,
  parameter int ACCEL_MULT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cnt,
  input  logic             i_cnt_cw,
  input  logic             i_wrap,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_pos,
  output logic             o_changed,
  output logic             o_at_min,
  output logic             o_at_max
);
  localparam int S     = WIDTH + 2;
  localparam int RST_C = POS_RESET < POS_MIN ? POS_MIN : (POS_RESET > POS_MAX ? POS_MAX : POS_RESET);
  localparam logic signed [S-1:0] MIN_S  = S'(POS_MIN);
  localparam logic signed [S-1:0] MAX_S  = S'(POS_MAX);
  localparam logic signed [S-1:0] RNG_S  = S'(POS_MAX - POS_MIN + 1);
  localparam logic signed [S-1:0] D_SLOW = S'(STEP);
  localparam logic signed [S-1:0] D_FAST = S'(STEP * ACCEL_MULT);
  if (!(POS_MIN < POS_MAX && POS_MAX < 2**WIDTH) || STEP * ACCEL_MULT > POS_MAX - POS_MIN + 1 || FAST_GAP < 1)
    $error("rotary_position_counter: illegal parameter set");
  logic fast;
`ifdef ROTARY_POS_ACCEL_EN
  rotary_accel_ctrl #(.FAST_GAP(FAST_GAP)) u_accel (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_cnt    (i_cnt),
    .i_cnt_cw (i_cnt_cw),
    .i_load   (i_load),
    .o_fast   (fast)
  );
`else
  assign fast = 1'b0;
`endif
  logic [WIDTH-1:0] pos_q, pos_d;
  logic changed_q, changed_d, at_min_q, at_min_d, at_max_q, at_max_d;
  logic signed [S-1:0] pos_s, ld_s, d, stp, wrp, sat, ld_c;
  always_comb begin
    pos_s     = {2'b00, pos_q};
    ld_s      = {2'b00, i_load_val};
    d         = fast ? D_FAST : D_SLOW;
    stp       = i_cnt_cw == DIR_CW ? pos_s + d : pos_s - d;
    // d never exceeds the range, so a single correction brings stp back in range
    wrp       = stp > MAX_S ? stp - RNG_S : (stp < MIN_S ? stp + RNG_S : stp);
    sat       = stp > MAX_S ? MAX_S : (stp < MIN_S ? MIN_S : stp);
    ld_c      = ld_s > MAX_S ? MAX_S : (ld_s < MIN_S ? MIN_S : ld_s);
    pos_d     = i_load ? WIDTH'(ld_c) : i_cnt ? WIDTH'(i_wrap == MODE_WRAP ? wrp : sat) : pos_q;
    changed_d = pos_d != pos_q;
    at_min_d  = pos_d == WIDTH'(POS_MIN);
    at_max_d  = pos_d == WIDTH'(POS_MAX);
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pos_q     <= WIDTH'(RST_C);
      changed_q <= 1'b0;
      at_min_q  <= RST_C == POS_MIN;
      at_max_q  <= RST_C == POS_MAX;
    end else begin
      pos_q     <= pos_d;
      changed_q <= changed_d;
      at_min_q  <= at_min_d;
      at_max_q  <= at_max_d;
    end
  end
  assign o_pos     = pos_q;
  assign o_changed = changed_q;
  assign o_at_min  = at_min_q;
  assign o_at_max  = at_max_q;
endmodule

// File: tb/tb_rotary_position_counter.sv
// tb_rotary_position_counter: scoreboard bench; stimulus queues expected outputs, a monitor
// compares them one cycle after each stimulus. Expectations follow ROTARY_POS_ACCEL_EN.
module tb_rotary_position_counter;
`ifdef ROTARY_POS_ACCEL_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif
  typedef struct {
    int         due;
    int         sel;
    logic [7:0] pos;
    logic       chg;
    string      nm;
  } exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [1:0] rst_n = '0, cnt = '0, cw = '0, wrap = '0, load = '0;
  logic [1:0] chg, amin, amax;
  logic [7:0] lval [2];
  logic [7:0] pos [2];
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  initial begin
    lval[0] = '0;
    lval[1] = '0;
  end
  // A: small 0..9 range for saturate/wrap/load; ACCEL_MULT=1 keeps its step at 1 in both builds
  rotary_position_counter #(.WIDTH(8), .POS_MIN(0), .POS_MAX(9), .POS_RESET(5), .STEP(1),
    .FAST_GAP(10), .ACCEL_MULT(1)) u_a (
    .i_clk(clk), .i_rst_n(rst_n[0]), .i_cnt(cnt[0]), .i_cnt_cw(cw[0]), .i_wrap(wrap[0]),
    .i_load(load[0]), .i_load_val(lval[0]), .o_pos(pos[0]), .o_changed(chg[0]),
    .o_at_min(amin[0]), .o_at_max(amax[0]));
  // B: acceleration scenario
  rotary_position_counter #(.WIDTH(8), .POS_MIN(0), .POS_MAX(255), .POS_RESET(100), .STEP(1),
    .FAST_GAP(10), .ACCEL_MULT(4)) u_b (
    .i_clk(clk), .i_rst_n(rst_n[1]), .i_cnt(cnt[1]), .i_cnt_cw(cw[1]), .i_wrap(wrap[1]),
    .i_load(load[1]), .i_load_val(lval[1]), .o_pos(pos[1]), .o_changed(chg[1]),
    .o_at_min(amin[1]), .o_at_max(amax[1]));

  task automatic drv(input int s, input logic r, input logic c, input logic w, input logic wr,
                     input logic l, input logic [7:0] v, input logic [7:0] ep, input logic ec,
                     input string nm);
    @(posedge clk);
    #1;
    rst_n[s] = r; cnt[s] = c; cw[s] = w; wrap[s] = wr; load[s] = l; lval[s] = v;
    q.push_back('{cyc + 1, s, ep, ec, nm});
  endtask
  task automatic step(input int s, input logic w, input logic wr, input logic [7:0] ep,
                      input logic ec, input string nm);
    drv(s, 1'b1, 1'b1, w, wr, 1'b0, 8'd0, ep, ec, nm);
  endtask
  task automatic idle(input int s, input logic [7:0] ep, input string nm);
    drv(s, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, ep, 1'b0, nm);
  endtask
  task automatic ld(input int s, input logic [7:0] v, input logic [7:0] ep, input logic ec,
                    input string nm);
    drv(s, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, v, ep, ec, nm);
  endtask

  initial begin
    exp_t e;
    logic [3:0] got, want;
    forever begin
      @(posedge clk);
      #2;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e    = q.pop_front();
        got  = {pos[e.sel] == e.pos, chg[e.sel], amin[e.sel], amax[e.sel]};
        want = {1'b1, e.chg, e.pos == 8'd0, e.pos == (e.sel == 0 ? 8'd9 : 8'd255)};
        n_cmp++;
        if (e.due != cyc || got !== want) begin
          n_bad++;
          $display("FAIL %s (dut %0d): got pos=%0d chg=%b min=%b max=%b, required pos=%0d chg=%b min=%b max=%b",
                   e.nm, e.sel, pos[e.sel], chg[e.sel], amin[e.sel], amax[e.sel],
                   e.pos, want[2], want[1], want[0]);
        end
      end
    end
  end

  initial begin
    logic [7:0] p;
    drv(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd5, 1'b0, "reset");
    idle(0, 8'd5, "reset_hold");
    for (int i = 1; i <= 4; i++) begin
      p = 8'(5 + i);
      step(0, 1'b1, 1'b0, p, 1'b1, "t1_cw");
      idle(0, p, "t1_pulse_width");
    end
    step(0, 1'b1, 1'b0, 8'd9, 1'b0, "t2_sat_max");
    step(0, 1'b0, 1'b0, 8'd8, 1'b1, "t2_ccw");
    step(0, 1'b1, 1'b1, 8'd9, 1'b1, "t3_up");
    step(0, 1'b1, 1'b1, 8'd0, 1'b1, "t3_wrap_max");
    step(0, 1'b0, 1'b1, 8'd9, 1'b1, "t3_wrap_min");
    for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b1, 8'(i), 1'b1, "t3_b2b");
    drv(0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd2, 1'b0, "t3_no_pulse");
    drv(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd200, 8'd9, 1'b1, "t4_load_clamp");
    ld(0, 8'd9, 8'd9, 1'b0, "t4_load_same");
    ld(0, 8'd3, 8'd3, 1'b1, "t4_load");
    drv(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3, 8'd3, 1'b0, "t4_load_wins");
    ld(0, 8'd0, 8'd0, 1'b1, "ld_min");
    step(0, 1'b0, 1'b0, 8'd0, 1'b0, "sat_min");
    drv(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd7, 8'd5, 1'b0, "t5_rst_override");
    idle(0, 8'd5, "t5_hold");
    drv(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd100, 1'b0, "b_reset");
    step(1, 1'b1, 1'b0, 8'd101, 1'b1, "b_first_slow");
    repeat (2) idle(1, 8'd101, "b_gap");
    step(1, 1'b1, 1'b0, ACC ? 8'd105 : 8'd102, 1'b1, "b_to_fast");
    p = ACC ? 8'd105 : 8'd102;
    repeat (2) idle(1, p, "b_gap");
    p = ACC ? 8'd109 : 8'd103;
    step(1, 1'b1, 1'b0, p, 1'b1, "b_fast");
    repeat (10) idle(1, p, "b_long_gap");
    p = ACC ? 8'd110 : 8'd104;
    step(1, 1'b1, 1'b0, p, 1'b1, "b_slow_after_gap");
    repeat (2) idle(1, p, "b_gap");
    p = ACC ? 8'd114 : 8'd105;
    step(1, 1'b1, 1'b0, p, 1'b1, "b_fast_again");
    repeat (2) idle(1, p, "b_gap");
    step(1, 1'b0, 1'b0, ACC ? 8'd113 : 8'd104, 1'b1, "b_reverse_slow");
    repeat (3) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
